// File: rtl/rs_port_arbiter.sv
// Round-robin arbiter for the shared register-file source-address port
// (ADD / MULT / MULADD) with a bounded hold time under contention.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif

module rs_port_arbiter #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int MAX_HOLD   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_add,
  input  logic       req_mult,
  input  logic       req_muladd,
  output logic       gnt_add,
  output logic       gnt_mult,
  output logic       gnt_muladd,
  output logic [1:0] rs_sel,
  output logic       port_busy,
  output logic       preempt
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rs_port_arbiter: MAX_HOLD must be within 2..255");
  end
  if (ADDR_WIDTH < 1) begin : g_bad_addr_width
    $error("rs_port_arbiter: ADDR_WIDTH must be positive");
  end

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
  localparam logic [1:0] SEL_MULADD = 2'd2;

  state_t     state_q, state_d;
  logic [2:0] req_vec, others, gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d, last_q, last_d, pick;
  logic [7:0] hold_q, hold_d;
  logic       pre_q, pre_d, busy_q;
  logic       owner_req, grant_new;

  // First requester in mask, searching from lst+1 in ADD->MULT->MULADD order.
  function automatic logic [1:0] rr_pick(input logic [2:0] mask, input logic [1:0] lst);
    logic [1:0]  res;
    logic        found;
    int unsigned idx;
    res   = '1;
    found = 1'b0;
    for (int unsigned off = 1; off <= 3; off++) begin
      idx = (32'(lst) + off) % 3;
      if (!found && mask[2'(idx)]) begin
        res   = 2'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign req_vec   = {req_muladd, req_mult, req_add};
  assign owner_req = |(req_vec & gnt_q);
  // The current owner never competes against itself, so a release or a
  // preemption always hands over to someone else.
  assign others    = req_vec & ~gnt_q;
  assign pick      = rr_pick(others, last_q);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    last_d    = last_q;
    hold_d    = hold_q;
    pre_d     = 1'b0;
    grant_new = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|others) grant_new = 1'b1;
      end
      OWN: begin
        if (!owner_req) begin
          if (|others) begin
            grant_new = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            sel_d   = '1;
            hold_d  = '0;
          end
        end else if (others == '0) begin
          if (hold_q < HOLD_MAX) hold_d = hold_q + 8'd1;
        end else if (hold_q < HOLD_LIM) begin
          hold_d = hold_q + 8'd1;
        end else begin
          grant_new = 1'b1;
          pre_d     = 1'b1;
        end
      end
      default: ;
    endcase
    if (grant_new) begin
      state_d = OWN;
      gnt_d   = 3'b001 << pick;
      sel_d   = pick;
      last_d  = pick;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '1;
      last_q  <= SEL_MULADD;
      hold_q  <= '0;
      pre_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      pre_q   <= pre_d;
      busy_q  <= |gnt_d;
    end
  end

  assign gnt_add    = gnt_q[0];
  assign gnt_mult   = gnt_q[1];
  assign gnt_muladd = gnt_q[2];
  assign rs_sel     = sel_q;
  assign port_busy  = busy_q;
  assign preempt    = pre_q;

endmodule

// File: tb/tb_rs_port_arbiter.sv
// Self-checking bench for rs_port_arbiter: directed scenarios plus randomized
// requests checked against an integer-level round-robin reference model.
module tb_rs_port_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk, rst_n;
  logic       req_add, req_mult, req_muladd;
  logic       gnt_add, gnt_mult, gnt_muladd;
  logic [1:0] rs_sel;
  logic       port_busy, preempt;
  logic [6:0] obs;

  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 = none), last granted, hold length.
  int m_owner, m_last, m_hold;
  bit m_pre;

  rs_port_arbiter #(.ADDR_WIDTH(5), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_add(req_add), .req_mult(req_mult), .req_muladd(req_muladd),
    .gnt_add(gnt_add), .gnt_mult(gnt_mult), .gnt_muladd(gnt_muladd),
    .rs_sel(rs_sel), .port_busy(port_busy), .preempt(preempt)
  );

  assign obs = {gnt_muladd, gnt_mult, gnt_add, rs_sel, port_busy, preempt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin : model_b
    int o, l, h, c;
    bit p, contend;
    bit [2:0] r;
    if (!rst_n) begin
      m_owner <= -1;
      m_last  <= 2;
      m_hold  <= 0;
      m_pre   <= 1'b0;
    end else begin
      r = {req_muladd, req_mult, req_add};
      o = m_owner; l = m_last; h = m_hold; p = 1'b0; c = -1;
      contend = 1'b0;
      for (int k = 0; k < 3; k++) if (k != o && r[k]) contend = 1'b1;
      if (o >= 0 && r[o] && !contend) begin
        h = (h + 1 > MAX_HOLD) ? MAX_HOLD : h + 1;
      end else if (o >= 0 && r[o] && h + 1 < MAX_HOLD) begin
        h = h + 1;
      end else begin
        for (int k = 1; k <= 3; k++)
          if (c < 0 && r[(l + k) % 3] && (l + k) % 3 != o) c = (l + k) % 3;
        if (o >= 0 && r[o]) p = 1'b1;
        o = c;
        h = 0;
        if (c >= 0) l = c;
      end
      m_owner <= o; m_last <= l; m_hold <= h; m_pre <= p;
    end
  end

  function automatic logic [6:0] exp_vec();
    logic [2:0] g;
    logic [1:0] s;
    g = (m_owner < 0) ? 3'b000 : 3'(3'b001 << m_owner);
    s = (m_owner < 0) ? 2'b11 : 2'(m_owner);
    return {g, s, (m_owner >= 0), m_pre};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req_add = 1'b0; req_mult = 1'b0; req_muladd = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      {req_muladd, req_mult, req_add} = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      checks++;
      if (obs !== 7'b000_11_0_0) begin
        errors++;
        $display("FAIL reset_hold: got %b expected %b", obs, 7'b000_11_0_0);
      end
    end
    #1 rst_n = 1'b1;
    {req_muladd, req_mult, req_add} = 3'b010;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== 7'b010_01_1_0) begin
      errors++;
      $display("FAIL reset_pre_mult_grant: got %b expected %b", obs, 7'b010_01_1_0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b000_11_0_0) begin
      errors++;
      $display("FAIL reset_async_midgrant: got %b expected %b", obs, 7'b000_11_0_0);
    end
  endtask

  task automatic test_single();
    do_reset();
    req_add = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(posedge clk); #1;
      checks++;
      if (gnt_add !== 1'b1 || rs_sel !== 2'b00 || obs !== exp_vec()) begin
        errors++;
        $display("FAIL single_grant c%0d: got %b expected %b", cyc, obs, exp_vec());
      end
    end
    req_add = 1'b0;
    for (int cyc = 6; cyc <= 7; cyc++) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== 7'b000_11_0_0) begin
        errors++;
        $display("FAIL single_release c%0d: got %b expected %b", cyc, obs, 7'b000_11_0_0);
      end
    end
  endtask

  task automatic test_contention();
    int cnt[3];
    logic [1:0] exp_sel;
    cnt = '{0, 0, 0};
    do_reset();
    {req_muladd, req_mult, req_add} = 3'b111;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      exp_sel = (cyc <= 6) ? 2'((cyc - 1) / 2) : 2'b11;
      checks++;
      if (rs_sel !== exp_sel || preempt !== 1'b0 || port_busy !== (cyc <= 6)
          || obs !== exp_vec()) begin
        errors++;
        $display("FAIL contention c%0d: got sel=%b obs=%b expected sel=%b obs=%b",
                 cyc, rs_sel, obs, exp_sel, exp_vec());
      end
      if (gnt_add)    begin cnt[0]++; if (cnt[0] == 2) req_add    = 1'b0; end
      if (gnt_mult)   begin cnt[1]++; if (cnt[1] == 2) req_mult   = 1'b0; end
      if (gnt_muladd) begin cnt[2]++; if (cnt[2] == 2) req_muladd = 1'b0; end
    end
  endtask

  task automatic test_preempt();
    logic [1:0] exp_sel;
    logic       exp_pre;
    do_reset();
    req_add = 1'b1;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      @(posedge clk); #1;
      exp_sel = (cyc <= 4) ? 2'b00 : (cyc <= 8) ? 2'b01 : (cyc <= 12) ? 2'b00 : 2'b01;
      exp_pre = (cyc == 5 || cyc == 9 || cyc == 13);
      checks++;
      if (rs_sel !== exp_sel || preempt !== exp_pre || obs !== exp_vec()) begin
        errors++;
        $display("FAIL preempt c%0d: got sel=%b pre=%b expected sel=%b pre=%b",
                 cyc, rs_sel, preempt, exp_sel, exp_pre);
      end
      if (cyc == 2) req_mult = 1'b1;
    end
  endtask

  task automatic test_no_contention();
    int bad;
    bad = 0;
    do_reset();
    req_muladd = 1'b1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(posedge clk); #1;
      checks++;
      if (gnt_muladd !== 1'b1 || preempt !== 1'b0 || rs_sel !== 2'b10) begin
        errors++;
        if (bad++ < 5)
          $display("FAIL solo_hold c%0d: got gnt=%b pre=%b sel=%b expected 1 0 10",
                   cyc, gnt_muladd, preempt, rs_sel);
      end
    end
    // Saturated hold count means a newcomer takes over on the very next edge.
    req_add = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs !== 7'b001_00_1_1 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL solo_then_contend: got %b expected %b", obs, 7'b001_00_1_1);
    end
  endtask

  task automatic test_fairness();
    int na, nm, prev, cur;
    na = 0; nm = 0; prev = -1;
    do_reset();
    req_add = 1'b1; req_mult = 1'b1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(posedge clk); #1;
      cur = gnt_add ? 0 : gnt_mult ? 1 : -1;
      checks++;
      if (cur < 0 || cur == prev || obs !== exp_vec()) begin
        errors++;
        $display("FAIL fairness c%0d: got owner=%0d prev=%0d obs=%b expected alternating obs=%b",
                 cyc, cur, prev, obs, exp_vec());
      end
      if (cur == 0) na++;
      if (cur == 1) nm++;
      prev = cur;
      req_add  = ~gnt_add;
      req_mult = ~gnt_mult;
    end
    checks++;
    if (na - nm > 1 || nm - na > 1 || na + nm != 100) begin
      errors++;
      $display("FAIL fairness_counts: got add=%0d mult=%0d expected 50/50 within 1", na, nm);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    do_reset();
    for (int cyc = 1; cyc <= 400; cyc++) begin
      {req_muladd, req_mult, req_add} = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        if (bad++ < 5)
          $display("FAIL random c%0d: got %b expected %b", cyc, obs, exp_vec());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_add = 1'b0; req_mult = 1'b0; req_muladd = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_preempt();
    test_no_contention();
    test_fairness();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/rs_port_arbiter.md
# rs_port_arbiter

Arbitrates the shared register-file source-address port between the ADD, MULT and MULADD controllers. Each controller raises a request and holds it while it needs the port. The arbiter grants exactly one owner at a time, using round-robin priority with a bounded hold time. It drives the registered select code consumed by the rs1/rs2 source-address muxes in front of the register file. Encoding and operand widths match the existing `defines.vh` settings.

## Interface
- ADDR_WIDTH, default `` `ADDR_WIDTH ``: register address width, kept for consistency with the source muxes; no address logic in this block.
- MAX_HOLD, default 8: maximum consecutive grant cycles under contention, legal range 2..255.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_add  input  1  ADD controller requests the port.
- req_mult  input  1  MULT controller requests the port.
- req_muladd  input  1  MULADD controller requests the port.
- gnt_add  output  1  ADD owns the port (registered).
- gnt_mult  output  1  MULT owns the port (registered).
- gnt_muladd  output  1  MULADD owns the port (registered).
- rs_sel  output  2  mux select: 2'b00 ADD, 2'b01 MULT, 2'b10 MULADD, 2'b11 no owner (registered).
- port_busy  output  1  any grant active.
- preempt  output  1  one-cycle pulse: previous owner lost the grant while still requesting.

## Operation
- States:
  - IDLE: no grant.
  - OWN: exactly one grant is high.
- Grant vector is always one-hot or zero. rs_sel always matches the grant; it is 2'b11 when no grant is high.
- Round-robin pointer `last` holds the most recently granted requester. Priority starts at `last+1` in the order ADD→MULT→MULADD→ADD.
- IDLE:
  - If any req is high, grant the highest-priority requester, update `last`, clear hold_cnt and go to OWN.
  - Otherwise stay in IDLE.
- OWN, owner req low (release):
  - Grant the highest-priority other requester with zero bubble, or go to IDLE if there are none.
  - The released owner is not considered that cycle.
- OWN, owner req high, no other req:
  - Keep the grant; hold_cnt saturates at MAX_HOLD.
  - No preemption, whatever the hold length.
- OWN, owner req high, another req high, hold_cnt < MAX_HOLD-1:
  - Keep the grant and increment hold_cnt.
- OWN, owner req high, another req high, hold_cnt ≥ MAX_HOLD-1:
  - Next cycle, grant the next requester in priority order, excluding the current owner.
  - Pulse preempt for that one cycle.
  - Update `last` and clear hold_cnt.
  - The preempted requester waits its round-robin turn.
- hold_cnt width is 8 bits, unsigned, and saturating (no wrap-around).
- A req rising and falling with no grant in between is ignored; requests are level-sensitive.
- Requesters must keep req high until they see their grant, and must stop driving the port the cycle after their grant falls.

## Timing
- Reset (rst_n low, asynchronous, takes effect immediately, including mid-grant):
  - all gnt_* = 0, rs_sel = 2'b11, port_busy = 0, preempt = 0.
  - state = IDLE, hold_cnt = 0, `last` = MULADD, so ADD has top priority after reset.
- Request-to-grant latency is 1 cycle: req sampled high at edge N gives the grant visible after edge N.
- Release-to-regrant latency is 1 cycle. Handover is direct: the old grant falls and the new grant rises on the same edge, with no IDLE cycle.
- Preemption: with a competitor waiting throughout, an owner holds at most MAX_HOLD cycles; the grant changes on the following edge.
- Outputs are all flops: no combinational path from req to gnt, rs_sel, port_busy or preempt.
- The first edge after reset deasserts evaluates the current requests normally.

## Test plan
- Reset: hold rst_n low with random reqs → gnt_* = 0, rs_sel = 2'b11, port_busy = 0, preempt = 0. Assert rst_n low during a MULT grant → outputs clear immediately, without waiting for a clock edge.
- Single requester: req_add high cycles 0–4 → gnt_add = 1 and rs_sel = 2'b00 for cycles 1–5. Then gnt_add = 0 and rs_sel = 2'b11 from cycle 6.
- Three-way contention from reset, each owner holds 2 cycles then releases → grants in order ADD, MULT, MULADD; rs_sel 00, 01, 10; zero bubble between owners; preempt never asserted.
- Preemption with MAX_HOLD = 4: req_add high from cycle 0, req_mult high from cycle 2, both held → gnt_add for cycles 1–4. At cycle 5: gnt_mult = 1, rs_sel = 2'b01, preempt = 1 for that cycle only. Then ADD is regranted after MULT's MAX_HOLD cycles.
- No contention: req_muladd held 300 cycles alone → gnt_muladd stays 1 throughout, preempt stays 0, hold_cnt saturates without wrap.
- Round-robin fairness: ADD and MULT re-request continuously with 1-cycle holds for 100 cycles → grants alternate strictly, and the grant counts differ by at most 1.
